// File: rtl/idex_hazard_unit.sv
// ID/EX hazard controller: shadow scoreboard of in-flight writers, RAW stall,
// EX-redirect squash, and saturating stall/flush performance counters.
module idex_hazard_unit #(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_IDEX,
    input  logic             rst_IDEX,
    input  logic             valid_ID,
    input  logic [4:0]       Rs1_addr_ID,
    input  logic [4:0]       Rs2_addr_ID,
    input  logic             Rs1_used_ID,
    input  logic             Rs2_used_ID,
    input  logic [4:0]       Rd_addr_ID,
    input  logic             RegWrite_ID,
    input  logic             redirect_EX,
    output logic             en_PC,
    output logic             en_IFID,
    output logic             en_IDEX,
    output logic             bubble_IDEX,
    output logic             flush_IFID,
    output logic [1:0]       hazard_src,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    // WB entry only participates when the regfile cannot bypass a same-cycle write
    localparam int NCMP = (WB_BYPASS != 0) ? 2 : 3;

    logic [2:0]      sb_v;
    logic [2:0][4:0] sb_rd;
    logic [2:0]      hit;
    logic            stall;

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_cmp
            assign hit[k] = (k < NCMP) & sb_v[k] &
                ((Rs1_used_ID & (Rs1_addr_ID != 5'd0) & (sb_rd[k] == Rs1_addr_ID)) |
                 (Rs2_used_ID & (Rs2_addr_ID != 5'd0) & (sb_rd[k] == Rs2_addr_ID)));
        end
    endgenerate

    assign stall   = valid_ID & (|hit) & ~redirect_EX;
    assign en_IDEX = 1'b1;

    always_comb begin
        en_PC       = 1'b1;
        en_IFID     = 1'b1;
        bubble_IDEX = 1'b0;
        flush_IFID  = 1'b0;
        hazard_src  = 2'd0;
        if (!rst_IDEX) begin
            if (redirect_EX) begin
                flush_IFID  = 1'b1;
                bubble_IDEX = 1'b1;
            end else if (stall) begin
                en_PC       = 1'b0;
                en_IFID     = 1'b0;
                bubble_IDEX = 1'b1;
                if (hit[0])      hazard_src = 2'd1;
                else if (hit[1]) hazard_src = 2'd2;
                else             hazard_src = 2'd3;
            end
        end
    end

    // Shifts every cycle; a bubble or squashed ID slot enters as an invalid entry
    always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
        if (rst_IDEX) begin
            sb_v  <= '0;
            sb_rd <= '0;
        end else begin
            sb_v[2]  <= sb_v[1];
            sb_rd[2] <= sb_rd[1];
            sb_v[1]  <= sb_v[0];
            sb_rd[1] <= sb_rd[0];
            sb_v[0]  <= valid_ID & RegWrite_ID & (Rd_addr_ID != 5'd0) & ~bubble_IDEX;
            sb_rd[0] <= Rd_addr_ID;
        end
    end

    always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
        if (rst_IDEX) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_EX && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_idex_hazard_unit.sv
// Bench for idex_hazard_unit: three instances (bypass, no bypass, 4-bit counters)
// share stimulus; directed scenarios plus randomized run against an in-flight model.
module tb_idex_hazard_unit;
    logic clk, rst;
    logic valid, rs1u, rs2u, rw, redir;
    logic [4:0] rs1, rs2, rd;

    logic [2:0] en_pc, en_ifid, en_idex, bubble, flush;
    logic [1:0] src [3];
    logic [15:0] sc0, sc1, fc0, fc1;
    logic [3:0]  sc2, fc2;
    int act_sc [3];
    int act_fc [3];

    int n_checks = 0;
    int n_errs   = 0;

    int byp  [3] = '{1, 0, 1};
    int cmax [3] = '{65535, 65535, 15};
    // model: writers in flight, indexed by age (0 = just issued into EX)
    int m_v  [3][3];
    int m_rd [3][3];
    int m_sc [3];
    int m_fc [3];

    idex_hazard_unit #(.WB_BYPASS(1), .CNT_W(16)) u_b1 (
        .clk_IDEX(clk), .rst_IDEX(rst), .valid_ID(valid),
        .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .Rs1_used_ID(rs1u), .Rs2_used_ID(rs2u),
        .Rd_addr_ID(rd), .RegWrite_ID(rw), .redirect_EX(redir),
        .en_PC(en_pc[0]), .en_IFID(en_ifid[0]), .en_IDEX(en_idex[0]), .bubble_IDEX(bubble[0]),
        .flush_IFID(flush[0]), .hazard_src(src[0]), .stall_cnt(sc0), .flush_cnt(fc0));

    idex_hazard_unit #(.WB_BYPASS(0), .CNT_W(16)) u_b0 (
        .clk_IDEX(clk), .rst_IDEX(rst), .valid_ID(valid),
        .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .Rs1_used_ID(rs1u), .Rs2_used_ID(rs2u),
        .Rd_addr_ID(rd), .RegWrite_ID(rw), .redirect_EX(redir),
        .en_PC(en_pc[1]), .en_IFID(en_ifid[1]), .en_IDEX(en_idex[1]), .bubble_IDEX(bubble[1]),
        .flush_IFID(flush[1]), .hazard_src(src[1]), .stall_cnt(sc1), .flush_cnt(fc1));

    idex_hazard_unit #(.WB_BYPASS(1), .CNT_W(4)) u_s4 (
        .clk_IDEX(clk), .rst_IDEX(rst), .valid_ID(valid),
        .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .Rs1_used_ID(rs1u), .Rs2_used_ID(rs2u),
        .Rd_addr_ID(rd), .RegWrite_ID(rw), .redirect_EX(redir),
        .en_PC(en_pc[2]), .en_IFID(en_ifid[2]), .en_IDEX(en_idex[2]), .bubble_IDEX(bubble[2]),
        .flush_IFID(flush[2]), .hazard_src(src[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    always_comb begin
        act_sc[0] = int'(sc0); act_sc[1] = int'(sc1); act_sc[2] = int'(sc2);
        act_fc[0] = int'(fc0); act_fc[1] = int'(fc1); act_fc[2] = int'(fc2);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit v, input bit u1, input int a1, input bit u2, input int a2,
                         input bit w, input int d, input bit r);
        valid = v; rs1u = u1; rs1 = 5'(a1); rs2u = u2; rs2 = 5'(a2);
        rw = w; rd = 5'(d); redir = r;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 3; a++) begin m_v[i][a] = 0; m_rd[i][a] = 0; end
            m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    // Stall if an operand names a nonzero register still being produced by a
    // writer younger than the regfile-visible age; the youngest such writer is reported.
    function automatic void model_eval(input int i, output bit st, output int s);
        int depth = (byp[i] != 0) ? 2 : 3;
        st = 0; s = 0;
        if (valid && !redir) begin
            for (int a = 0; a < depth; a++) begin
                if (!st && m_v[i][a] != 0 && m_rd[i][a] != 0 &&
                    ((rs1u && int'(rs1) == m_rd[i][a]) || (rs2u && int'(rs2) == m_rd[i][a]))) begin
                    st = 1; s = a + 1;
                end
            end
        end
    endfunction

    task automatic tick();
        bit st [3];
        int s;
        for (int i = 0; i < 3; i++) model_eval(i, st[i], s);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i][2] = m_v[i][1]; m_rd[i][2] = m_rd[i][1];
                m_v[i][1] = m_v[i][0]; m_rd[i][1] = m_rd[i][0];
                m_v[i][0] = (valid && rw && rd != 0 && !st[i] && !redir) ? 1 : 0;
                m_rd[i][0] = int'(rd);
                if (st[i] && m_sc[i] < cmax[i]) m_sc[i]++;
                if (redir && m_fc[i] < cmax[i]) m_fc[i]++;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 0);
        tick();
        drive(1, 1, 5, 0, 0, 1, 6, 0);
        tick();
        #1;
        n_checks++;
        if (en_pc[0] !== 1'b0) begin n_errs++; $display("FAIL reset_pre_stall: en_PC=%0b expected 0", en_pc[0]); end
        n_checks++;
        if (sc0 !== 16'd1) begin n_errs++; $display("FAIL reset_pre_cnt: stall_cnt=%0d expected 1", sc0); end
        // assert reset mid-cycle with a redirect pending as well
        #2 rst = 1'b1; redir = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (en_pc[i] !== 1'b1 || en_ifid[i] !== 1'b1 || en_idex[i] !== 1'b1 || bubble[i] !== 1'b0 ||
                flush[i] !== 1'b0 || src[i] !== 2'd0) begin
                n_errs++;
                $display("FAIL reset_outputs inst%0d: pc=%0b ifid=%0b idex=%0b bub=%0b fl=%0b src=%0d expected 1 1 1 0 0 0",
                         i, en_pc[i], en_ifid[i], en_idex[i], bubble[i], flush[i], src[i]);
            end
            n_checks++;
            if (act_sc[i] !== 0 || act_fc[i] !== 0) begin
                n_errs++; $display("FAIL reset_counters inst%0d: stall=%0d flush=%0d expected 0 0", i, act_sc[i], act_fc[i]);
            end
        end
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0; redir = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (en_pc[i] !== 1'b1 || src[i] !== 2'd0) begin
                n_errs++; $display("FAIL reset_no_residual inst%0d: en_PC=%0b src=%0d expected 1 0", i, en_pc[i], src[i]);
            end
        end
        tick();
    endtask

    task automatic test_raw();
        int exp_src3 [3] = '{0, 3, 0};
        int exp_cnt  [3] = '{2, 3, 2};
        apply_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 0);
        #1;
        n_checks++;
        if (en_pc[0] !== 1'b1) begin n_errs++; $display("FAIL raw_producer: en_PC=%0b expected 1", en_pc[0]); end
        tick();
        drive(1, 1, 5, 1, 1, 1, 6, 0);
        for (int c = 1; c <= 2; c++) begin
            #1;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (src[i] !== 2'(c) || bubble[i] !== 1'b1 || en_pc[i] !== 1'b0 || en_ifid[i] !== 1'b0) begin
                    n_errs++;
                    $display("FAIL raw_stall%0d inst%0d: src=%0d bub=%0b pc=%0b ifid=%0b expected %0d 1 0 0",
                             c, i, src[i], bubble[i], en_pc[i], en_ifid[i], c);
                end
            end
            tick();
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (int'(src[i]) !== exp_src3[i] || bubble[i] !== (exp_src3[i] != 0)) begin
                n_errs++; $display("FAIL raw_cycle3 inst%0d: src=%0d bub=%0b expected %0d", i, src[i], bubble[i], exp_src3[i]);
            end
        end
        tick();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (src[i] !== 2'd0 || en_pc[i] !== 1'b1) begin
                n_errs++; $display("FAIL raw_issue inst%0d: src=%0d en_PC=%0b expected 0 1", i, src[i], en_pc[i]);
            end
            n_checks++;
            if (act_sc[i] !== exp_cnt[i]) begin
                n_errs++; $display("FAIL raw_stall_cnt inst%0d: got %0d expected %0d", i, act_sc[i], exp_cnt[i]);
            end
        end
        tick();
    endtask

    task automatic test_x0_unused();
        apply_reset();
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 1, 0, 1, 0, 1, 8, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (src[i] !== 2'd0 || en_pc[i] !== 1'b1) begin
                n_errs++; $display("FAIL x0_no_hazard inst%0d: src=%0d en_PC=%0b expected 0 1", i, src[i], en_pc[i]);
            end
        end
        tick();
        drive(1, 0, 0, 0, 0, 1, 7, 0);
        tick();
        drive(1, 1, 3, 0, 7, 1, 9, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (src[i] !== 2'd0 || bubble[i] !== 1'b0) begin
                n_errs++; $display("FAIL unused_rs2 inst%0d: src=%0d bub=%0b expected 0 0", i, src[i], bubble[i]);
            end
        end
        // same cycle: invalid slot ignored, then the real dependency must be seen
        drive(0, 1, 7, 1, 7, 0, 0, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (src[i] !== 2'd0 || en_pc[i] !== 1'b1) begin
                n_errs++; $display("FAIL invalid_id inst%0d: src=%0d en_PC=%0b expected 0 1", i, src[i], en_pc[i]);
            end
        end
        drive(1, 0, 0, 1, 7, 0, 0, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (src[i] !== 2'd1 || en_pc[i] !== 1'b0) begin
                n_errs++; $display("FAIL rs2_hazard inst%0d: src=%0d en_PC=%0b expected 1 0", i, src[i], en_pc[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_redirect();
        apply_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 0);
        tick();
        drive(1, 1, 5, 0, 0, 1, 6, 0);
        #1;
        n_checks++;
        if (en_pc[0] !== 1'b0) begin n_errs++; $display("FAIL redir_pre_stall: en_PC=%0b expected 0", en_pc[0]); end
        redir = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (flush[i] !== 1'b1 || bubble[i] !== 1'b1 || en_pc[i] !== 1'b1 || en_ifid[i] !== 1'b1 || src[i] !== 2'd0) begin
                n_errs++;
                $display("FAIL redir_outputs inst%0d: fl=%0b bub=%0b pc=%0b ifid=%0b src=%0d expected 1 1 1 1 0",
                         i, flush[i], bubble[i], en_pc[i], en_ifid[i], src[i]);
            end
        end
        tick();
        // squashed instruction wrote x6; it must not have been tracked
        drive(1, 1, 6, 0, 0, 1, 7, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (en_pc[i] !== 1'b1 || src[i] !== 2'd0) begin
                n_errs++; $display("FAIL redir_no_push inst%0d: en_PC=%0b src=%0d expected 1 0", i, en_pc[i], src[i]);
            end
            n_checks++;
            if (act_sc[i] !== 0 || act_fc[i] !== 1) begin
                n_errs++; $display("FAIL redir_counters inst%0d: stall=%0d flush=%0d expected 0 1", i, act_sc[i], act_fc[i]);
            end
        end
        tick();
    endtask

    task automatic test_saturation();
        int exp30 [3] = '{20, 22, 15};
        apply_reset();
        // addi x5, x5, 1 held in ID: each issue hazards on itself
        drive(1, 1, 5, 0, 0, 1, 5, 0);
        repeat (30) tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (act_sc[i] !== exp30[i]) begin
                n_errs++; $display("FAIL sat_stall_cnt inst%0d: got %0d expected %0d", i, act_sc[i], exp30[i]);
            end
        end
        repeat (5) tick();
        n_checks++;
        if (sc2 !== 4'd15) begin n_errs++; $display("FAIL sat_hold: stall_cnt=%0d expected 15", sc2); end
    endtask

    task automatic test_random();
        bit st;
        int s;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) == 0) apply_reset();
            drive($urandom_range(9) != 0, $urandom_range(1), $urandom_range(7), $urandom_range(1),
                  $urandom_range(7), $urandom_range(3) != 0, $urandom_range(7), $urandom_range(9) == 0);
            #1;
            for (int i = 0; i < 3; i++) begin
                model_eval(i, st, s);
                n_checks++;
                if (en_pc[i] !== (redir | ~st) || en_ifid[i] !== (redir | ~st) || en_idex[i] !== 1'b1 ||
                    bubble[i] !== (redir | st) || flush[i] !== redir || int'(src[i]) !== s) begin
                    n_errs++;
                    $display("FAIL rand_ctrl n%0d inst%0d: pc=%0b ifid=%0b idex=%0b bub=%0b fl=%0b src=%0d expected stall=%0b redir=%0b src=%0d",
                             n, i, en_pc[i], en_ifid[i], en_idex[i], bubble[i], flush[i], src[i], st, redir, s);
                end
                n_checks++;
                if (act_sc[i] !== m_sc[i] || act_fc[i] !== m_fc[i]) begin
                    n_errs++;
                    $display("FAIL rand_cnt n%0d inst%0d: stall=%0d flush=%0d expected %0d %0d",
                             n, i, act_sc[i], act_fc[i], m_sc[i], m_fc[i]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_raw();
        test_x0_unused();
        test_redirect();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/idex_hazard_unit.md
Name: idex_hazard_unit

Overview:
- Issue-side hazard controller for the ID/EX boundary of the 5-stage pcpu pipeline.
- Tracks in-flight register writers with a shadow scoreboard that advances in lockstep with the ID/EX, EX/MEM and MEM/WB registers.
- On RAW hazards it stalls PC and IF/ID and injects bubbles into ID/EX; no forwarding exists.
- On an EX-resolved branch or jump it squashes the IF/ID and ID stages.
- Keeps saturating stall and flush performance counters.

Parameters:
WB_BYPASS, 1, 1: regfile is write-before-read, so WB-stage writers are not hazards; 0: WB writers also cause a stall
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
clk_IDEX  in  1  pipeline clock, rising edge
rst_IDEX  in  1  asynchronous, active-high reset
valid_ID  in  1  ID stage holds a real instruction
Rs1_addr_ID  in  5  source register 1 of the ID instruction
Rs2_addr_ID  in  5  source register 2 of the ID instruction
Rs1_used_ID  in  1  ID instruction reads rs1
Rs2_used_ID  in  1  ID instruction reads rs2
Rd_addr_ID  in  5  destination register of the ID instruction
RegWrite_ID  in  1  ID instruction writes rd
redirect_EX  in  1  taken branch or jump resolved in EX this cycle
en_PC  out  1  PC update enable
en_IFID  out  1  IF/ID register enable
en_IDEX  out  1  ID/EX register enable; constant 1
bubble_IDEX  out  1  force zero control fields into ID/EX (NOP)
flush_IFID  out  1  load a NOP into IF/ID
hazard_src  out  2  0 none, 1 EX match, 2 MEM match, 3 WB match; reports the youngest matching stage
stall_cnt  out  CNT_W  cycles stalled, saturating
flush_cnt  out  CNT_W  redirects taken, saturating

Behaviour:
- Reset is asynchronous, rst_IDEX high clears all state:
  - sb_v[0..2] = 0, sb_rd[0..2] = 0, stall_cnt = 0, flush_cnt = 0.
  - While rst_IDEX is high, outputs are forced to en_PC = 1, en_IFID = 1, en_IDEX = 1, bubble_IDEX = 0, flush_IFID = 0, hazard_src = 0.
  - Reset asserted mid-stall or mid-flush drops all pending state with no residual stall.
- Scoreboard layout, one entry per downstream stage: {sb_v, sb_rd}; entry 0 = EX, 1 = MEM, 2 = WB.
- match(k, a):
  - True when sb_v[k] = 1, sb_rd[k] = a and a != 0.
  - x0 never hazards.
- Stages compared:
  - Entries 0 and 1 always.
  - Entry 2 only when WB_BYPASS = 0.
- stall, combinational:
  - stall = valid_ID & ((Rs1_used_ID & match(any, Rs1_addr_ID)) | (Rs2_used_ID & match(any, Rs2_addr_ID))) & !redirect_EX.
- hazard_src:
  - When stall = 1, reports the lowest-index matching entry.
  - Otherwise 0.
- Combinational outputs, priority redirect > stall > run:
  - redirect_EX = 1: flush_IFID = 1, bubble_IDEX = 1, en_PC = 1, en_IFID = 1.
  - stall = 1: en_PC = 0, en_IFID = 0, bubble_IDEX = 1, flush_IFID = 0.
  - Otherwise: en_PC = 1, en_IFID = 1, bubble_IDEX = 0, flush_IFID = 0.
- Scoreboard update every rising edge, no enable:
  - sb[2] <= sb[1]; sb[1] <= sb[0].
  - sb_v[0] <= valid_ID & RegWrite_ID & (Rd_addr_ID != 0) & !bubble_IDEX; sb_rd[0] <= Rd_addr_ID.
  - A bubble therefore pushes an invalid entry.
- The branch in EX during a redirect keeps its own entry; it shifts normally, since a JAL rd write must still be tracked.
- Load-use latency with WB_BYPASS = 1: a dependent instruction immediately after its producer stalls exactly 2 cycles. With WB_BYPASS = 0 it stalls 3 cycles.
- Counters:
  - stall_cnt increments on each edge where stall = 1.
  - flush_cnt increments on each edge where redirect_EX = 1.
  - Both saturate at all-ones with no wrap.
- Simultaneous redirect and stall: redirect wins. The stalled ID instruction is squashed, nothing is pushed, stall_cnt does not increment, and the stall disappears the next cycle unless the new ID instruction hazards.
- valid_ID = 0: never stalls and pushes an invalid entry.

Test Plan:
- Reset: assert rst_IDEX mid-cycle -> outputs immediately en_PC = 1, bubble_IDEX = 0, flush_IFID = 0; stall_cnt = 0; scoreboard empty.
- RAW back-to-back, WB_BYPASS = 1: issue addi x5 (RegWrite, rd = 5), then add x6, x5, x1 -> stall for 2 cycles with hazard_src 1 then 2, bubble_IDEX = 1 both cycles; third cycle issues; stall_cnt = 2.
- WB_BYPASS = 0, same stimulus -> 3 stall cycles, hazard_src sequence 1, 2, 3; stall_cnt = 3.
- x0 and unused operands: producer rd = x0, or consumer with Rs2_used_ID = 0 matching rs2 -> no stall, hazard_src = 0.
- Redirect during stall: consumer stalled on x5 and redirect_EX = 1 in the same cycle -> flush_IFID = 1, bubble_IDEX = 1, en_PC = 1; stall_cnt unchanged; flush_cnt increments by 1.
- Counter saturation, CNT_W = 4: hold a permanent hazard by repeatedly issuing a producer, for 20 stall cycles -> stall_cnt = 15 and holds.
